// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 datapath widths and write-arbiter state encoding
package lc3_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2**ADDR_W;

  typedef enum logic [1:0] {
    RST,
    CLEAR,
    RUN
  } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write port arbiter: CPU writeback vs debug writes, with clear sequencing
module regfile_write_arbiter #(
  parameter int DATA_W     = lc3_pkg::DATA_W,
  parameter int ADDR_W     = lc3_pkg::ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic              i_cpu_ld,
  input  logic [ADDR_W-1:0] i_cpu_dr,
  input  logic [DATA_W-1:0] i_bus,
  input  logic              i_dbg_req,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_data,
  input  logic              i_clr_req,
  output logic              o_ld_reg,
  output logic [ADDR_W-1:0] o_dr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_dbg_ack,
  output logic              o_cpu_stall,
  output logic              o_busy
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam int SW       = $clog2(STARVE_MAX + 1);

  lc3_pkg::arb_state_t state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
  logic [SW-1:0]       starve_cnt, starve_cnt_nxt;
  logic                dbg_grant;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state      <= lc3_pkg::RST;
      clr_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    clr_cnt_nxt    = clr_cnt;
    starve_cnt_nxt = '0;
    dbg_grant      = 1'b0;
    o_ld_reg       = 1'b0;
    o_dr_addr      = '0;
    o_wr_data      = '0;
    o_dbg_ack      = 1'b0;
    o_cpu_stall    = i_cpu_ld;
    o_busy         = 1'b1;

    case (state)
      lc3_pkg::RST: begin
        state_nxt   = lc3_pkg::CLEAR;
        clr_cnt_nxt = '0;
      end

      lc3_pkg::CLEAR: begin
        o_ld_reg    = 1'b1;
        o_dr_addr   = clr_cnt;
        // Counter wraps to zero naturally on the last register.
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == ADDR_W'(NUM_REGS - 1)) begin
          state_nxt = lc3_pkg::RUN;
        end
      end

      lc3_pkg::RUN: begin
        o_busy      = 1'b0;
        o_cpu_stall = 1'b0;
        dbg_grant   = i_dbg_req && (!i_cpu_ld || starve_cnt == SW'(STARVE_MAX));
        if (dbg_grant) begin
          o_ld_reg    = 1'b1;
          o_dr_addr   = i_dbg_addr;
          o_wr_data   = i_dbg_data;
          o_dbg_ack   = 1'b1;
          o_cpu_stall = i_cpu_ld;
        end else if (i_cpu_ld) begin
          o_ld_reg  = 1'b1;
          o_dr_addr = i_cpu_dr;
          o_wr_data = i_bus;
        end

        if (i_dbg_req && !dbg_grant) begin
          starve_cnt_nxt = (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
        end

        // This cycle's write still commits; clearing starts next cycle.
        if (i_clr_req) begin
          state_nxt   = lc3_pkg::CLEAR;
          clr_cnt_nxt = '0;
        end
      end

      default: begin
        state_nxt   = lc3_pkg::RST;
        clr_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized and directed bench for regfile_write_arbiter against a phase-count model
module tb_regfile_write_arbiter;

  localparam int DW     = 16;
  localparam int AW     = 3;
  localparam int NREGS  = 8;
  localparam int STARVE = 4;

  logic          i_CLK;
  logic          i_RST_N;
  logic          i_cpu_ld;
  logic [AW-1:0] i_cpu_dr;
  logic [DW-1:0] i_bus;
  logic          i_dbg_req;
  logic [AW-1:0] i_dbg_addr;
  logic [DW-1:0] i_dbg_data;
  logic          i_clr_req;
  logic          o_ld_reg;
  logic [AW-1:0] o_dr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_dbg_ack;
  logic          o_cpu_stall;
  logic          o_busy;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(STARVE)) dut (
    .i_CLK       (i_CLK),
    .i_RST_N     (i_RST_N),
    .i_cpu_ld    (i_cpu_ld),
    .i_cpu_dr    (i_cpu_dr),
    .i_bus       (i_bus),
    .i_dbg_req   (i_dbg_req),
    .i_dbg_addr  (i_dbg_addr),
    .i_dbg_data  (i_dbg_data),
    .i_clr_req   (i_clr_req),
    .o_ld_reg    (o_ld_reg),
    .o_dr_addr   (o_dr_addr),
    .o_wr_data   (o_wr_data),
    .o_dbg_ack   (o_dbg_ack),
    .o_cpu_stall (o_cpu_stall),
    .o_busy      (o_busy)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  int n_vec = 0;
  int n_err = 0;

  // phase: -1 waiting after reset, 0..NREGS-1 clearing that register, NREGS running
  int phase  = -1;
  int waited = 0;

  logic          exp_ld, exp_ack, exp_stall, exp_busy;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          last_stall = 1'b0;
  logic          last_ack   = 1'b0;

  logic [DW-1:0] ref_regs [NREGS];
  logic [DW-1:0] dut_regs [NREGS];
  logic          d_ld;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_outputs();
    exp_ld = 1'b0; exp_addr = '0; exp_data = '0; exp_ack = 1'b0;
    exp_stall = i_cpu_ld; exp_busy = 1'b1;
    if (i_RST_N && phase >= 0 && phase < NREGS) begin
      exp_ld   = 1'b1;
      exp_addr = AW'(phase);
    end else if (i_RST_N && phase == NREGS) begin
      exp_busy  = 1'b0;
      exp_stall = 1'b0;
      if (i_dbg_req && (!i_cpu_ld || waited >= STARVE)) begin
        exp_ld = 1'b1; exp_addr = i_dbg_addr; exp_data = i_dbg_data;
        exp_ack = 1'b1; exp_stall = i_cpu_ld;
      end else if (i_cpu_ld) begin
        exp_ld = 1'b1; exp_addr = i_cpu_dr; exp_data = i_bus;
      end
    end
  endtask

  task automatic model_advance();
    if (!i_RST_N) begin
      phase = -1; waited = 0;
    end else if (phase < NREGS) begin
      phase++; waited = 0;
    end else begin
      if (i_dbg_req && !exp_ack) waited = (waited < STARVE) ? waited + 1 : waited;
      else waited = 0;
      if (i_clr_req) phase = 0;
    end
  endtask

  task automatic cycle();
    #4;
    model_outputs();
    check_eq("ld_reg",    o_ld_reg,    exp_ld);
    check_eq("dr_addr",   o_dr_addr,   exp_addr);
    check_eq("wr_data",   o_wr_data,   exp_data);
    check_eq("dbg_ack",   o_dbg_ack,   exp_ack);
    check_eq("cpu_stall", o_cpu_stall, exp_stall);
    check_eq("busy",      o_busy,      exp_busy);
    d_ld = o_ld_reg; d_addr = o_dr_addr; d_data = o_wr_data;
    last_stall = exp_stall;
    last_ack   = exp_ack;
    @(posedge i_CLK);
    if (d_ld) dut_regs[d_addr] = d_data;
    if (exp_ld) ref_regs[exp_addr] = exp_data;
    model_advance();
    #1;
  endtask

  task automatic idle_inputs();
    i_cpu_ld = 0; i_cpu_dr = '0; i_bus = '0;
    i_dbg_req = 0; i_dbg_addr = '0; i_dbg_data = '0; i_clr_req = 0;
  endtask

  int busy_cnt;
  int ack_wait;

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      ref_regs[i] = '0;
      dut_regs[i] = '1;
    end
    i_RST_N = 1'b0;
    idle_inputs();
    @(posedge i_CLK); #1;
    repeat (2) cycle();
    i_cpu_ld = 1; i_cpu_dr = 3'd6; i_bus = 16'h5555;
    cycle();
    idle_inputs();

    // Release: busy must last exactly NREGS+1 cycles
    i_RST_N = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) i_clr_req = 1;
      else i_clr_req = 0;
      #4;
      if (o_busy) busy_cnt++;
      #0;
      cycle_rest();
    end
    check_eq("busy_len", busy_cnt, NREGS + 1);

    // CPU write, no debug
    i_cpu_ld = 1; i_cpu_dr = 3'd3; i_bus = 16'hBEEF;
    cycle();
    idle_inputs();
    cycle();

    // Debug starves behind continuous CPU writes, granted on 5th cycle
    i_cpu_ld = 1; i_cpu_dr = 3'd1; i_bus = 16'hA0A0;
    i_dbg_req = 1; i_dbg_addr = 3'd5; i_dbg_data = 16'h1234;
    ack_wait = 0;
    for (int i = 0; i < 20; i++) begin
      ack_wait++;
      cycle();
      if (last_ack) break;
    end
    check_eq("starve_wait", ack_wait, STARVE + 1);
    i_dbg_req = 0;
    cycle();
    idle_inputs();
    cycle();

    // Clear request with concurrent CPU write, plus a mid-CLEAR pulse
    i_cpu_ld = 1; i_cpu_dr = 3'd2; i_bus = 16'h7777; i_clr_req = 1;
    cycle();
    i_clr_req = 0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      i_clr_req = (i == 3);
      #4;
      if (o_busy) busy_cnt++;
      cycle_rest();
    end
    check_eq("clr_len", busy_cnt, NREGS);
    idle_inputs();

    // Asynchronous reset during the 4th clear cycle
    i_clr_req = 1;
    cycle();
    i_clr_req = 0;
    repeat (3) cycle();
    i_RST_N = 1'b0;
    #1;
    check_eq("async_ld", o_ld_reg, 1'b0);
    check_eq("async_busy", o_busy, 1'b1);
    #2;
    cycle_rest();
    cycle();
    i_RST_N = 1'b1;
    repeat (NREGS + 2) cycle();

    // Randomized traffic obeying the hold-while-stalled / hold-until-acked rules
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        i_cpu_ld = ($urandom_range(0, 9) < 6);
        i_cpu_dr = AW'($urandom);
        i_bus    = DW'($urandom);
      end
      if (!i_dbg_req || last_ack) begin
        i_dbg_req  = ($urandom_range(0, 9) < 3);
        i_dbg_addr = AW'($urandom);
        i_dbg_data = DW'($urandom);
      end
      i_clr_req = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 199) == 0) i_RST_N = 1'b0;
      else i_RST_N = 1'b1;
      cycle();
    end
    idle_inputs();
    i_RST_N = 1'b1;
    repeat (NREGS + 2) cycle();

    for (int i = 0; i < NREGS; i++) check_eq($sformatf("reg%0d", i), dut_regs[i], ref_regs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Same as cycle() but entered 4 time units into the cycle
  task automatic cycle_rest();
    model_outputs();
    check_eq("ld_reg",    o_ld_reg,    exp_ld);
    check_eq("dr_addr",   o_dr_addr,   exp_addr);
    check_eq("wr_data",   o_wr_data,   exp_data);
    check_eq("dbg_ack",   o_dbg_ack,   exp_ack);
    check_eq("cpu_stall", o_cpu_stall, exp_stall);
    check_eq("busy",      o_busy,      exp_busy);
    d_ld = o_ld_reg; d_addr = o_dr_addr; d_data = o_wr_data;
    last_stall = exp_stall;
    last_ack   = exp_ack;
    @(posedge i_CLK);
    if (d_ld) dut_regs[d_addr] = d_data;
    if (exp_ld) ref_regs[exp_addr] = exp_data;
    model_advance();
    #1;
  endtask

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): DATA_W, 16, register width.
REQ-002 ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W = 8.
REQ-003 STARVE_MAX, 4, max cycles a pending debug write waits behind CPU writes.
REQ-004 Ports (name  direction  width  meaning), one clock, reset asynchronous active-low:
- i_CLK  in  1  sole clock, rising edge.
- i_RST_N  in  1  asynchronous active-low reset.
- i_cpu_ld  in  1  CPU writeback request (control-store LD_REG).
- i_cpu_dr  in  ADDR_W  CPU destination register.
- i_bus  in  DATA_W  CPU write data (datapath bus).
- i_dbg_req  in  1  debug write request, held until acked.
- i_dbg_addr  in  ADDR_W  debug destination register.
- i_dbg_data  in  DATA_W  debug write data.
- i_clr_req  in  1  request zeroing of all registers.
- o_ld_reg  out  1  register-file write enable.
- o_dr_addr  out  ADDR_W  register-file write address.
- o_wr_data  out  DATA_W  register-file write data.
- o_dbg_ack  out  1  debug write committed at this cycle's edge.
- o_cpu_stall  out  1  CPU write request not granted this cycle.
- o_busy  out  1  reset or clear sequence in progress.

Function
REQ-005 FSM states SHALL be RST, CLEAR, RUN, plus a clear counter clr_cnt (ADDR_W bits) and a starvation counter starve_cnt (0..STARVE_MAX, saturating).
REQ-006 Write-port outputs SHALL be combinational from current state and inputs; the register file commits at the same rising edge (zero added latency).
REQ-007 RST: o_ld_reg=0, o_dbg_ack=0, o_busy=1, o_cpu_stall=i_cpu_ld; next state CLEAR, clr_cnt=0.
REQ-008 CLEAR: o_ld_reg=1, o_dr_addr=clr_cnt, o_wr_data=0, o_busy=1, o_cpu_stall=i_cpu_ld, o_dbg_ack=0; clr_cnt increments each cycle; at clr_cnt=NUM_REGS-1 next state RUN, clr_cnt wraps to 0.
REQ-009 CLEAR SHALL take exactly NUM_REGS cycles; i_clr_req during CLEAR or RST is ignored (no restart).
REQ-010 RUN, debug grant: i_dbg_req=1 and (i_cpu_ld=0 or starve_cnt=STARVE_MAX) -> o_ld_reg=1, address/data from debug port, o_dbg_ack=1, o_cpu_stall=i_cpu_ld.
REQ-011 RUN, CPU grant: i_cpu_ld=1 and no debug grant -> o_ld_reg=1, address/data from CPU port, o_cpu_stall=0, o_dbg_ack=0.
REQ-012 RUN, neither: o_ld_reg=0, o_dr_addr=0, o_wr_data=0, o_cpu_stall=0, o_dbg_ack=0; o_busy=0 throughout RUN.
REQ-013 starve_cnt SHALL increment when i_dbg_req=1 and not granted, saturate at STARVE_MAX, and clear on debug grant, when i_dbg_req=0, or outside RUN.
REQ-014 i_clr_req=1 in RUN SHALL move to CLEAR next cycle; the current cycle's RUN arbitration still applies.
REQ-015 Stalled CPU requests SHALL NOT be buffered; the CPU holds i_cpu_ld/i_cpu_dr/i_bus while o_cpu_stall=1.
REQ-016 Requester data/address SHALL pass unmodified; no width conversion.

Reset
REQ-017 i_RST_N=0 SHALL asynchronously force state RST, clr_cnt=0, starve_cnt=0; outputs per REQ-007 while asserted.
REQ-018 Reset asserted mid-CLEAR or mid-RUN SHALL abort immediately; a full CLEAR follows release.
REQ-019 First rising edge after release: RST->CLEAR; o_busy falls after NUM_REGS+1 edges.

Structure
REQ-020 DATA_W, ADDR_W, NUM_REGS, and the state enum (RST, CLEAR, RUN) SHALL live in the shared lc3_pkg package.
REQ-021 Single module, no sub-modules; instantiated beside register_file, driving its LD_REG, DR address and write data.

Verification
REQ-022 Reset release -> o_busy high 9 edges, o_ld_reg=1 with o_dr_addr 0..7 and o_wr_data=0 on edges 2..9, then RUN.
REQ-023 RUN, i_cpu_ld=1 dr=3 bus=0xBEEF, no debug -> o_ld_reg=1, o_dr_addr=3, o_wr_data=0xBEEF, o_cpu_stall=0.
REQ-024 RUN, i_cpu_ld=1 continuously, i_dbg_req=1 addr=5 data=0x1234 -> no ack 4 cycles, ack on 5th with o_cpu_stall=1, o_dr_addr=5; CPU regains port next cycle.
REQ-025 RUN, i_clr_req=1 with i_cpu_ld=1 dr=2 -> R2 written that cycle, then 8 CLEAR cycles; i_clr_req pulse mid-CLEAR does not extend it.
REQ-026 i_RST_N low at CLEAR cycle 4 -> o_ld_reg=0 immediately (asynchronous); after release, full 8-register clear from address 0.
